fifo_wptr_full: RTL and testbench
=================================

FIFO_WPTR_FULL -- requirements
Module: fifo_wptr_full

Interface
REQ-001 SHALL have parameter ADDRSIZE, default 5: FIFO address width; depth = 2^ADDRSIZE entries.
REQ-002 SHALL have parameter AFULL_THRESH, default 28: fill level at or above which almost_full asserts.
REQ-003 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset that is synchronous and active-high.
REQ-005 SHALL have port clear, input, 1, synchronous flush of write-side state.
REQ-006 SHALL have port winc, input, 1, write request from the producer.
REQ-007 SHALL have port rptr_sync, input, ADDRSIZE+1, Gray-coded read pointer already synchronized into clk domain.
REQ-008 SHALL have port wen, output, 1, memory write strobe (combinational: winc AND NOT wfull).
REQ-009 SHALL have port waddr, output, ADDRSIZE, memory write address (low ADDRSIZE bits of binary write count).
REQ-010 SHALL have port wptr, output, ADDRSIZE+1, registered Gray write pointer sent to the read-side synchronizer.
REQ-011 SHALL have port wfull, output, 1, registered full flag.
REQ-012 SHALL have port wlevel, output, ADDRSIZE+1, registered fill level, 0..2^ADDRSIZE.
REQ-013 SHALL have port overflow, output, 1, sticky flag for a write attempted while full.
REQ-014 SHALL have port almost_full, output, 1, registered threshold flag.

Function
REQ-015 SHALL hold a binary count wbin (ADDRSIZE+1 bits); wbin_next = wbin + (winc AND NOT wfull), modulo 2^(ADDRSIZE+1).
REQ-016 SHALL register wptr = wbin_next XOR (wbin_next >> 1); wptr changes only on the edge that accepts a write.
REQ-017 SHALL register wfull = 1 when Gray(wbin_next) equals rptr_sync with its two MSBs inverted and remaining bits equal; else 0.
REQ-018 SHALL assert wfull on the same edge that accepts the write filling the last entry; no extra latency.
REQ-019 SHALL deassert wfull on the first edge after rptr_sync advances; a winc on that edge is still refused.
REQ-020 SHALL ignore winc while wfull=1: wen=0; wbin, waddr and wptr unchanged.
REQ-021 SHALL register wlevel = wbin_next - gray2bin(rptr_sync), modulo 2^(ADDRSIZE+1).
REQ-022 SHALL set overflow on the edge after winc=1 with wfull=1 and hold it until rst or clear.
REQ-023 SHALL wrap wbin from 2^(ADDRSIZE+1)-1 to 0 with no discontinuity in full or level behaviour.
REQ-024 SHALL, on a simultaneous accepted write and rptr_sync change, compute wfull and wlevel from both new values in one cycle.

Reset
REQ-025 SHALL, on rst=1 at an edge, drive wbin=0, wptr=0, waddr=0, wfull=0, wlevel=0, overflow=0 and almost_full=0 on that edge.
REQ-026 SHALL give clear the same effect as rst; rst takes priority over clear, and clear takes priority over winc.
REQ-027 SHALL discard a write requested in the same cycle as rst or clear; wen SHALL be 0 in that cycle.

Configuration
REQ-028 SHALL compile almost_full logic only when macro FIFO_WPTR_ALMOST_FULL_EN is defined.
REQ-029 SHALL, with FIFO_WPTR_ALMOST_FULL_EN defined, register almost_full = 1 when the next wlevel >= AFULL_THRESH, else 0.
REQ-030 SHALL, without FIFO_WPTR_ALMOST_FULL_EN defined, keep the almost_full port and tie it to constant 0 with no threshold logic.

Verification (ADDRSIZE=5, AFULL_THRESH=28)
REQ-031 SHALL cover reset: rst=1 for 2 cycles with winc=1 -> wen=0, wptr=6'b000000, wfull=0, wlevel=0, overflow=0.
REQ-032 SHALL cover fill: rptr_sync=0, 32 consecutive winc -> wfull=1 on the 32nd edge, wptr=6'b110000, waddr=0, wlevel=32; almost_full=1 from the 28th edge (macro defined).
REQ-033 SHALL cover overflow: 33rd winc while full -> wen=0, wptr stays 6'b110000, overflow=1 next edge and remains 1 for 10+ cycles.
REQ-034 SHALL cover drain: rptr_sync changes to 6'b000001 -> wfull=0 and wlevel=31 on the next edge; the next winc is accepted with waddr=0.
REQ-035 SHALL cover wrap: 100 writes with rptr_sync tracking wptr one cycle late -> wfull never asserts, wptr returns to 0 after 64 writes, waddr sequence continuous.
REQ-036 SHALL cover clear: clear=1 with winc=1 mid-fill at wlevel=17 and overflow=1 -> all outputs 0 next edge; macro undefined -> almost_full=0 throughout.

Source files
------------

// File: rtl/fifo_wptr_full.sv
// rtl/fifo_wptr_full.sv - FIFO write-side pointer, full/level/overflow logic.
// Optional almost_full threshold logic enabled by FIFO_WPTR_ALMOST_FULL_EN.
module fifo_wptr_full #(
  parameter int ADDRSIZE     = 5,
  parameter int AFULL_THRESH = 28
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   rptr_sync,
  output logic                wen,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                overflow,
  output logic                almost_full
);

  logic [ADDRSIZE:0] wbin;
  logic [ADDRSIZE:0] wbin_next;
  logic [ADDRSIZE:0] wgray_next;
  logic [ADDRSIZE:0] rbin;
  logic [ADDRSIZE:0] level_next;
  logic              full_next;
  logic              flush;

  if (ADDRSIZE < 2 || AFULL_THRESH < 0) begin : g_param_check
    $error("fifo_wptr_full: ADDRSIZE must be >= 2 and AFULL_THRESH >= 0");
  end

  assign flush = rst | clear;

  // A write coinciding with rst/clear is dropped, so the strobe is masked too.
  assign wen        = winc & ~wfull & ~flush;
  assign wbin_next  = wbin + {{ADDRSIZE{1'b0}}, wen};
  assign wgray_next = wbin_next ^ (wbin_next >> 1);
  assign waddr      = wbin[ADDRSIZE-1:0];

  always_comb begin
    rbin = '0;
    for (int i = 0; i <= ADDRSIZE; i++) begin
      rbin[i] = ^(rptr_sync >> i);
    end
  end

  assign level_next = wbin_next - rbin;
  // Full when the write pointer is exactly one lap ahead of the read pointer.
  assign full_next  = (wgray_next == {~rptr_sync[ADDRSIZE:ADDRSIZE-1],
                                       rptr_sync[ADDRSIZE-2:0]});

  always_ff @(posedge clk) begin
    if (flush) begin
      wbin     <= '0;
      wptr     <= '0;
      wfull    <= 1'b0;
      wlevel   <= '0;
      overflow <= 1'b0;
    end else begin
      wbin   <= wbin_next;
      wptr   <= wgray_next;
      wfull  <= full_next;
      wlevel <= level_next;
      if (winc && wfull) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef FIFO_WPTR_ALMOST_FULL_EN
  always_ff @(posedge clk) begin
    if (flush) begin
      almost_full <= 1'b0;
    end else begin
      almost_full <= (32'(level_next) >= AFULL_THRESH);
    end
  end
`else
  assign almost_full = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wptr_full.sv
// tb/tb_fifo_wptr_full.sv - self-checking bench for fifo_wptr_full.
module tb_fifo_wptr_full;
  localparam int AS    = 5;
  localparam int DEPTH = 32;
  localparam int MODV  = 64;
  localparam int TH    = 28;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clear = 1'b0;
  logic          winc = 1'b0;
  logic [AS:0]   rptr_sync = '0;
  logic          wen;
  logic [AS-1:0] waddr;
  logic [AS:0]   wptr;
  logic          wfull;
  logic [AS:0]   wlevel;
  logic          overflow;
  logic          almost_full;

  fifo_wptr_full #(.ADDRSIZE(AS), .AFULL_THRESH(TH)) dut (
    .clk(clk), .rst(rst), .clear(clear), .winc(winc), .rptr_sync(rptr_sync),
    .wen(wen), .waddr(waddr), .wptr(wptr), .wfull(wfull), .wlevel(wlevel),
    .overflow(overflow), .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: count of accepted writes and occupancy, in plain integers.
  int m_wcnt = 0;
  int m_level = 0;
  bit m_full = 0;
  bit m_ovf = 0;
  bit m_af = 0;
  int wraps = 0;

  function automatic logic [AS:0] gray(input int b);
    logic [31:0] v;
    v = b;
    return v[AS:0] ^ (v[AS:0] >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit w, input bit c, input bit r, input int rb);
    winc = w; clear = c; rst = r; rptr_sync = gray(rb);
    #2;
    chk("wen", 32'(wen), 32'(w && !m_full && !c && !r));
    @(posedge clk);
    if (r || c) begin
      m_wcnt = 0; m_level = 0; m_full = 0; m_ovf = 0; m_af = 0;
    end else begin
      if (w && m_full) m_ovf = 1;
      else if (w) m_wcnt = (m_wcnt + 1) % MODV;
      m_level = (m_wcnt - rb + MODV) % MODV;
      m_full  = (m_level == DEPTH);
`ifdef FIFO_WPTR_ALMOST_FULL_EN
      m_af = (m_level >= TH);
`else
      m_af = 0;
`endif
    end
    #1;
    chk("wptr",        32'(wptr),        32'(gray(m_wcnt)));
    chk("waddr",       32'(waddr),       32'(m_wcnt % DEPTH));
    chk("wfull",       32'(wfull),       32'(m_full));
    chk("wlevel",      32'(wlevel),      32'(m_level));
    chk("overflow",    32'(overflow),    32'(m_ovf));
    chk("almost_full", 32'(almost_full), 32'(m_af));
  endtask

  initial begin
    int rb;
    // Reset held two cycles with a pending write
    step(1, 0, 1, 0);
    step(1, 0, 1, 0);
    chk("reset_wptr", 32'(wptr), 32'h0);

    // Fill to full with reader parked at 0
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 0);
    chk("fill_wptr",   32'(wptr),   32'h30);
    chk("fill_wlevel", 32'(wlevel), 32'd32);
    chk("fill_wfull",  32'(wfull),  32'd1);
    chk("fill_waddr",  32'(waddr),  32'd0);

    // Overflow attempt, then sticky hold
    step(1, 0, 0, 0);
    chk("ovf_wptr", 32'(wptr), 32'h30);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Drain one entry
    step(0, 0, 0, 1);
    chk("drain_wlevel", 32'(wlevel), 32'd31);
    chk("drain_waddr",  32'(waddr),  32'd0);
    step(1, 0, 0, 1);

    // Wrap: reader follows the registered write pointer one cycle late
    step(0, 1, 0, 0);
    for (int i = 0; i < 100; i++) begin
      step(1, 0, 0, m_wcnt);
      if (wptr === '0) wraps++;
    end
    chk("wrap_count", 32'(wraps), 32'd1);

    // Clear mid-fill with overflow set and level 17
    step(0, 1, 0, 0);
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 15);
    chk("pre_clear_level", 32'(wlevel), 32'd17);
    step(1, 1, 0, 15);
    chk("clear_level", 32'(wlevel), 32'd0);
    chk("clear_ovf",   32'(overflow), 32'd0);

    // Randomized traffic with a well-behaved reader
    rb = 0;
    step(0, 1, 0, 0);
    for (int i = 0; i < 600; i++) begin
      bit w;
      bit c;
      w = ($urandom % 4) != 0;
      c = ($urandom % 80) == 0;
      if (rb != m_wcnt && ($urandom % 3) == 0) rb = (rb + 1) % MODV;
      if (c) rb = 0;
      step(w, c, 0, rb);
      if (c) rb = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
